// File: rtl/barr_arb.sv
// barr_arb: shares one combinational Barrett reducer between NREQ requesters.
// Each requester may have one operand outstanding; an accepted operand sits
// in a single issue stage for one cycle, then the reducer result is parked
// in that requester's result slot until consumed.
// Optional build macro: BARR_ARB_PRIO_EN selects fixed priority (lowest index
// wins) instead of round-robin arbitration.
module barr_arb #(
    parameter int NREQ = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NREQ-1:0]    req_valid_i,
    output logic [NREQ-1:0]    req_ready_o,
    input  logic [NREQ*16-1:0] req_data_i,
    output logic [NREQ-1:0]    rsp_valid_o,
    input  logic [NREQ-1:0]    rsp_ready_i,
    output logic [NREQ*16-1:0] rsp_data_o,
    output logic [15:0]        barr_op_o,
    input  logic [15:0]        barr_res_i,
    output logic               busy_o,
    output logic [31:0]        accept_cnt_o
);
    localparam int PW = $clog2(NREQ);

    logic [NREQ-1:0]       rsp_vld_q, rsp_vld_d;
    logic [NREQ-1:0][15:0] rsp_dat_q, rsp_dat_d;
    logic                  iss_vld_q, iss_vld_d;
    logic [PW-1:0]         iss_tag_q, iss_tag_d;
    logic [15:0]           iss_op_q, iss_op_d;
    logic [31:0]           cnt_q, cnt_d;
`ifndef BARR_ARB_PRIO_EN
    logic [PW-1:0]         rr_q, rr_d;
`endif

    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   gnt_idx;
    logic [PW-1:0]   idx;
    logic            gnt_any;
    logic [15:0]     gnt_op;

    // A requester is eligible only with nothing in flight and no held result
    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++)
            elig[i] = !rsp_vld_q[i] && !(iss_vld_q && iss_tag_q == PW'(i));
    end

    // Pick one requester per cycle; ready is suppressed while in reset
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        gnt_op  = '0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef BARR_ARB_PRIO_EN
            idx = PW'(k);
`else
            idx = PW'((int'(rr_q) + k) % NREQ);
`endif
            if (!gnt_any && !rst_i && req_valid_i[idx] && elig[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_any && gnt_idx == PW'(i)) begin
                gnt[i] = 1'b1;
                gnt_op = req_data_i[i*16 +: 16];
            end
        end
    end

    // Next state: issue stage load, result capture/consume, counter, pointer
    always_comb begin
        iss_vld_d = gnt_any;
        iss_tag_d = gnt_any ? gnt_idx : iss_tag_q;
        iss_op_d  = gnt_any ? gnt_op : iss_op_q;
        cnt_d     = cnt_q + 32'(gnt_any);
`ifndef BARR_ARB_PRIO_EN
        rr_d = rr_q;
        if (gnt_any)
            rr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
`endif
        rsp_vld_d = rsp_vld_q;
        rsp_dat_d = rsp_dat_q;
        for (int i = 0; i < NREQ; i++) begin
            // consume only when a result is actually held
            if (rsp_vld_q[i] && rsp_ready_i[i]) begin
                rsp_vld_d[i] = 1'b0;
                rsp_dat_d[i] = '0;
            end
            // slot cannot be held while its operand is in flight, so no clash
            if (iss_vld_q && iss_tag_q == PW'(i)) begin
                rsp_vld_d[i] = 1'b1;
                rsp_dat_d[i] = barr_res_i;
            end
        end
    end

    // State registers with synchronous reset; in-flight work is dropped
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            iss_vld_q <= 1'b0;
            iss_tag_q <= '0;
            iss_op_q  <= '0;
            cnt_q     <= '0;
            rsp_vld_q <= '0;
            rsp_dat_q <= '0;
`ifndef BARR_ARB_PRIO_EN
            rr_q      <= '0;
`endif
        end else begin
            iss_vld_q <= iss_vld_d;
            iss_tag_q <= iss_tag_d;
            iss_op_q  <= iss_op_d;
            cnt_q     <= cnt_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_dat_q <= rsp_dat_d;
`ifndef BARR_ARB_PRIO_EN
            rr_q      <= rr_d;
`endif
        end
    end

    // Result data is zero whenever its slot is empty
    always_comb begin
        rsp_data_o = '0;
        for (int i = 0; i < NREQ; i++)
            if (rsp_vld_q[i]) rsp_data_o[i*16 +: 16] = rsp_dat_q[i];
    end

    assign req_ready_o  = gnt;
    assign rsp_valid_o  = rsp_vld_q;
    assign barr_op_o    = iss_vld_q ? iss_op_q : 16'h0;
    assign busy_o       = iss_vld_q || (|rsp_vld_q);
    assign accept_cnt_o = cnt_q;

endmodule
